fetch_pc_gen: RTL and testbench

Fetch-stage PC sequencer between the next-PC predictor and the instruction cache. It holds the fetch PC and issues 64-bit aligned fetch requests, one outstanding at a time. It feeds the current PC to the predictor and loads the predictor's next-PC whenever a request is accepted. Returned instruction pairs are buffered in a 2-entry queue toward decode, and the queue is flushed on an execute-stage redirect.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_skid_fifo.sv | 61 ++++++
 rtl/fetch_pc_gen.sv | 138 +++++++++++++
 tb/tb_fetch_pc_gen.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the fetch PC sequencer.
// Boot vector, FSM states, fetch packet layout and queue sizing.
package fetch_pkg;

  localparam logic [31:0] BOOT_VECTOR_DEF = 32'h8000_0000;

  localparam int FETCH_FIFO_DEPTH = 2;
  localparam int FETCH_PTR_W = $clog2(FETCH_FIFO_DEPTH);
  localparam int FETCH_CNT_W = $clog2(FETCH_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] instr;
    logic [1:0]  pred;
    logic        fault;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: small synchronous packet queue toward decode.
// Ports: clk/rst_n, flush (wins), push/din, pop/dout, count.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_pkt_t             din,
  input  logic                   pop,
  output fetch_pkt_t             dout,
  output logic [FETCH_CNT_W-1:0] count
);

  fetch_pkt_t mem [FETCH_FIFO_DEPTH];

  logic [FETCH_PTR_W-1:0] rd_ptr;
  logic [FETCH_PTR_W-1:0] wr_ptr;
  logic                   full;
  logic                   empty;
  logic                   do_push;
  logic                   do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FETCH_CNT_W'(FETCH_FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head is zero when empty so idle outputs stay quiet.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FETCH_FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + FETCH_PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + FETCH_PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + FETCH_CNT_W'(1);
        2'b01:   count <= count - FETCH_CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC sequencer, one outstanding icache request.
// Ports: predictor (pc/next pc), icache req/resp, decode packet out.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_VECTOR = BOOT_VECTOR_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i,
  input  logic        branch_request_i,
  input  logic [31:0] branch_pc_i,
  input  logic [31:0] next_pc_f_i,
  input  logic [1:0]  next_taken_f_i,
  output logic [31:0] pc_f_o,
  output logic        pc_accept_o,
  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic        icache_error_i,
  input  logic [63:0] icache_inst_i,
  output logic        fetch_valid_o,
  output logic [63:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic [1:0]  fetch_pred_o,
  output logic        fetch_fault_o,
  input  logic        fetch_accept_i
);

  fetch_state_e state_q;

  logic [31:0] pc_q;
  logic [31:0] meta_pc_q;
  logic [1:0]  meta_pred_q;
  logic        inflight_q;
  logic        drop_q;

  logic [FETCH_CNT_W-1:0] fifo_count;
  logic [2:0]             occ;
  logic                   resp;
  logic                   push;
  logic                   pop;
  fetch_pkt_t             push_pkt;
  fetch_pkt_t             head;

  // Low PC bits are dropped on load; only word-aligned PCs exist.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{next_pc_f_i[1:0], branch_pc_i[1:0]};

  // The in-flight request reserves a queue slot for its response.
  assign occ = 3'(fifo_count) + 3'(inflight_q);

  assign icache_rd_o = (state_q == RUN) & fetch_enable_i
                     & ~inflight_q & ~branch_request_i
                     & (occ < 3'(FETCH_FIFO_DEPTH));
  assign pc_accept_o = icache_rd_o & icache_accept_i;
  assign icache_pc_o = {pc_q[31:3], 3'b000};
  assign pc_f_o      = pc_q;

  assign resp = inflight_q & icache_valid_i;
  assign push = resp & ~drop_q & ~branch_request_i;
  assign pop  = fetch_accept_i & fetch_valid_o;

  assign push_pkt.pc    = meta_pc_q;
  assign push_pkt.instr = icache_inst_i;
  assign push_pkt.pred  = meta_pred_q;
  assign push_pkt.fault = icache_error_i;

  fetch_skid_fifo u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .flush (branch_request_i),
    .push  (push),
    .din   (push_pkt),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count)
  );

  assign fetch_valid_o = (fifo_count != '0);
  assign fetch_instr_o = head.instr;
  assign fetch_pc_o    = head.pc;
  assign fetch_pred_o  = head.pred;
  assign fetch_fault_o = head.fault;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q        <= BOOT_VECTOR;
      meta_pc_q   <= '0;
      meta_pred_q <= '0;
      inflight_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      if (branch_request_i) begin
        pc_q <= {branch_pc_i[31:2], 2'b00};
      end else if (pc_accept_o) begin
        pc_q <= {next_pc_f_i[31:2], 2'b00};
      end
      if (pc_accept_o) begin
        meta_pc_q   <= pc_q;
        meta_pred_q <= next_taken_f_i;
      end
      if (pc_accept_o) begin
        inflight_q <= 1'b1;
      end else if (resp) begin
        inflight_q <= 1'b0;
      end
      // A response landing with the redirect is discarded directly.
      if (branch_request_i & inflight_q & ~icache_valid_i) begin
        drop_q <= 1'b1;
      end else if (resp) begin
        drop_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fetch_enable_i) state_q <= RUN;
        end
        RUN: begin
          if (pc_accept_o) state_q <= WAIT;
          else if (!fetch_enable_i) state_q <= IDLE;
        end
        WAIT: begin
          if (resp) state_q <= fetch_enable_i ? RUN : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: random and directed stimulus for fetch_pc_gen.
// Checks every cycle against a queue-based behavioural model.
module tb_fetch_pc_gen;
  import fetch_pkg::*;

  localparam logic [31:0] BOOT = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        fetch_enable_i = 1'b0;
  logic        branch_request_i = 1'b0;
  logic [31:0] branch_pc_i = '0;
  logic [31:0] next_pc_f_i = '0;
  logic [1:0]  next_taken_f_i = '0;
  logic [31:0] pc_f_o;
  logic        pc_accept_o;
  logic        icache_rd_o;
  logic [31:0] icache_pc_o;
  logic        icache_accept_i = 1'b0;
  logic        icache_valid_i = 1'b0;
  logic        icache_error_i = 1'b0;
  logic [63:0] icache_inst_i = '0;
  logic        fetch_valid_o;
  logic [63:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic [1:0]  fetch_pred_o;
  logic        fetch_fault_o;
  logic        fetch_accept_i = 1'b0;

  always #5 clk_i = ~clk_i;

  fetch_pc_gen dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .fetch_enable_i   (fetch_enable_i),
    .branch_request_i (branch_request_i),
    .branch_pc_i      (branch_pc_i),
    .next_pc_f_i      (next_pc_f_i),
    .next_taken_f_i   (next_taken_f_i),
    .pc_f_o           (pc_f_o),
    .pc_accept_o      (pc_accept_o),
    .icache_rd_o      (icache_rd_o),
    .icache_pc_o      (icache_pc_o),
    .icache_accept_i  (icache_accept_i),
    .icache_valid_i   (icache_valid_i),
    .icache_error_i   (icache_error_i),
    .icache_inst_i    (icache_inst_i),
    .fetch_valid_o    (fetch_valid_o),
    .fetch_instr_o    (fetch_instr_o),
    .fetch_pc_o       (fetch_pc_o),
    .fetch_pred_o     (fetch_pred_o),
    .fetch_fault_o    (fetch_fault_o),
    .fetch_accept_i   (fetch_accept_i)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [63:0] instr;
    logic [1:0]  pred;
    logic        fault;
  } pkt_t;

  pkt_t        q[$];
  logic [31:0] m_pc;
  logic [31:0] m_meta_pc;
  logic [1:0]  m_meta_pred;
  bit          m_busy;
  bit          m_drop;
  bit          m_en_prev;
  bit          dut_acc;

  bit c_pend = 0;
  int c_wait = 0;
  int lat_fix = 0;
  int err_pct = 0;

  task automatic model_reset();
    q.delete();
    m_pc      = BOOT;
    m_busy    = 0;
    m_drop    = 0;
    m_en_prev = 0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    model_reset();
    check("rst_pcf", pc_f_o, BOOT);
    check("rst_ipc", icache_pc_o, BOOT & 32'hFFFF_FFF8);
    check("rst_rd", icache_rd_o, 0);
    check("rst_acc", pc_accept_o, 0);
    check("rst_valid", fetch_valid_o, 0);
    check("rst_instr", fetch_instr_o, 0);
    check("rst_fpc", fetch_pc_o, 0);
    check("rst_pred", fetch_pred_o, 0);
    check("rst_fault", fetch_fault_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Called at a negedge with the bench inputs already set.
  task automatic tick();
    bit   rd;
    bit   acc;
    bit   resp;
    bit   cv;
    pkt_t p;
    cv = c_pend && (c_wait == 0);
    icache_valid_i = cv;
    if (!c_pend && $urandom_range(0, 19) == 0) icache_valid_i = 1'b1;
    icache_inst_i  = {$urandom, $urandom};
    icache_error_i = ($urandom_range(0, 99) < err_pct);
    #1;
    rd  = m_en_prev && fetch_enable_i && !m_busy
       && !branch_request_i && (q.size() < FETCH_FIFO_DEPTH);
    acc = rd && icache_accept_i;
    dut_acc = pc_accept_o;
    check("icache_rd", icache_rd_o, rd);
    check("pc_accept", pc_accept_o, acc);
    check("icache_pc", icache_pc_o, m_pc & 32'hFFFF_FFF8);
    check("pc_f", pc_f_o, m_pc);
    check("fetch_valid", fetch_valid_o, q.size() != 0);
    if (q.size() != 0) begin
      check("fetch_pc", fetch_pc_o, q[0].pc);
      check("fetch_instr", fetch_instr_o, q[0].instr);
      check("fetch_pred", fetch_pred_o, q[0].pred);
      check("fetch_fault", fetch_fault_o, q[0].fault);
    end
    resp = m_busy && icache_valid_i;
    if (branch_request_i) begin
      q.delete();
      m_drop = m_busy && !icache_valid_i;
      m_pc   = {branch_pc_i[31:2], 2'b00};
      if (resp) m_busy = 0;
    end else begin
      if (fetch_accept_i && q.size() != 0) void'(q.pop_front());
      if (resp) begin
        if (!m_drop) begin
          p.pc    = m_meta_pc;
          p.instr = icache_inst_i;
          p.pred  = m_meta_pred;
          p.fault = icache_error_i;
          q.push_back(p);
        end
        m_busy = 0;
        m_drop = 0;
      end
    end
    if (acc) begin
      m_meta_pc   = m_pc;
      m_meta_pred = next_taken_f_i;
      m_busy      = 1;
      m_pc        = {next_pc_f_i[31:2], 2'b00};
    end
    m_en_prev = fetch_enable_i;
    if (cv) c_pend = 0;
    else if (c_pend) c_wait--;
    if (acc) begin
      c_pend = 1;
      c_wait = ((lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3))) - 1;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    bit seen;
    model_reset();
    @(negedge clk_i);
    do_reset();

    // Sequential fetch from the boot vector.
    fetch_enable_i  = 1'b1;
    icache_accept_i = 1'b1;
    lat_fix = 1;
    next_pc_f_i = m_pc + 32'd8;
    tick();
    next_pc_f_i = m_pc + 32'd8;
    tick();
    check("first_pcf", pc_f_o, 32'h8000_0008);

    // Predicted jump, packet carries the taken bits.
    do_reset();
    tick();
    next_pc_f_i    = 32'h8000_0104;
    next_taken_f_i = 2'b01;
    tick();
    check("jump_pcf", pc_f_o, 32'h8000_0104);
    check("jump_ipc", icache_pc_o, 32'h8000_0100);
    next_pc_f_i    = m_pc + 32'd8;
    next_taken_f_i = 2'b00;
    tick();
    check("jump_valid", fetch_valid_o, 1);
    check("jump_fpc", fetch_pc_o, 32'h8000_0000);
    check("jump_pred", fetch_pred_o, 2'b01);

    // Decode stalled: queue fills and requests stop.
    fetch_accept_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      next_pc_f_i = m_pc + 32'd8;
      tick();
    end
    check("full_valid", fetch_valid_o, 1);
    check("full_rd", icache_rd_o, 0);
    fetch_accept_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      next_pc_f_i = m_pc + 32'd8;
      tick();
    end

    // Redirect while a slow request is in flight.
    lat_fix = 3;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      next_pc_f_i = m_pc + 32'd8;
      tick();
      seen = dut_acc;
    end
    check("redir_wait_acc", seen, 1);
    branch_request_i = 1'b1;
    branch_pc_i      = 32'h8000_0204;
    tick();
    branch_request_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      next_pc_f_i = m_pc + 32'd8;
      #1;
      if (icache_rd_o) seen = 1;
      else tick();
    end
    check("redir_rd_seen", seen, 1);
    check("redir_ipc", icache_pc_o, 32'h8000_0200);
    for (int i = 0; i < 8; i++) begin
      next_pc_f_i = m_pc + 32'd8;
      tick();
    end

    // Redirect together with a response and a decode pop.
    lat_fix = 1;
    fetch_accept_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (c_pend && c_wait == 0 && q.size() != 0) seen = 1;
      else begin
        next_pc_f_i = m_pc + 32'd8;
        tick();
      end
    end
    check("flush_setup", seen, 1);
    branch_request_i = 1'b1;
    branch_pc_i      = 32'h8000_0400;
    fetch_accept_i   = 1'b1;
    tick();
    branch_request_i = 1'b0;
    check("flush_valid", fetch_valid_o, 0);

    // Faulting response is delivered and fetch continues.
    err_pct = 100;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      next_pc_f_i = m_pc + 32'd8;
      #1;
      if (fetch_valid_o) seen = 1;
      else tick();
    end
    check("fault_seen", seen, 1);
    check("fault_bit", fetch_fault_o, 1);
    err_pct = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      next_pc_f_i = m_pc + 32'd8;
      tick();
      seen = dut_acc;
    end
    check("fault_next_req", seen, 1);

    // Random traffic with one reset in the middle.
    lat_fix = 0;
    err_pct = 20;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      fetch_enable_i   = ($urandom_range(0, 9) != 0);
      branch_request_i = ($urandom_range(0, 9) == 0);
      branch_pc_i      = $urandom;
      next_pc_f_i      = ($urandom_range(0, 3) != 0) ? m_pc + 32'd8
                                                     : 32'($urandom);
      next_taken_f_i   = 2'($urandom_range(0, 3));
      icache_accept_i  = ($urandom_range(0, 9) < 7);
      fetch_accept_i   = $urandom_range(0, 1) != 0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
